// File: rtl/bcd_cascade_counter.sv
// Multi-digit BCD counter with per-digit modulus, up/down, load, and lookahead tc.
// Define BCD_CASCADE_SATURATE_EN to saturate at the terminal value instead of wrapping.
module bcd_cascade_counter #(
   parameter int unsigned         DIGITS  = 2,
   parameter logic [4*DIGITS-1:0] MOD_VEC = {4'd6, 4'd10}
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                up,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   output logic [4*DIGITS-1:0] count,
   output logic                tc,
   output logic                carry_out
);

`ifdef BCD_CASCADE_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic [4*DIGITS-1:0] count_q, count_d, count_step;
   logic                carry_q, carry_d;
   logic [DIGITS-1:0]   at_max, at_zero, step;

   always_comb begin
      at_max  = '0;
      at_zero = '0;
      for (int i = 0; i < DIGITS; i++) begin
         at_max[i]  = count_q[4*i +: 4] == MOD_VEC[4*i +: 4] - 4'd1;
         at_zero[i] = count_q[4*i +: 4] == 4'd0;
      end
      tc = up ? &at_max : &at_zero;
   end

   // A digit steps only when every lower digit is at its rollover value.
   always_comb begin
      step       = '0;
      step[0]    = 1'b1;
      count_step = count_q;
      for (int i = 1; i < DIGITS; i++)
         step[i] = step[i-1] & (up ? at_max[i-1] : at_zero[i-1]);
      for (int i = 0; i < DIGITS; i++) begin
         if (step[i]) begin
            if (up)
               count_step[4*i +: 4] = at_max[i] ? 4'd0
                                    : count_q[4*i +: 4] + 4'd1;
            else
               count_step[4*i +: 4] = at_zero[i] ? MOD_VEC[4*i +: 4] - 4'd1
                                     : count_q[4*i +: 4] - 4'd1;
         end
      end
   end

   always_comb begin
      count_d = count_q;
      carry_d = 1'b0;
      if (load) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] >= MOD_VEC[4*i +: 4])
               count_d[4*i +: 4] = MOD_VEC[4*i +: 4] - 4'd1;
            else
               count_d[4*i +: 4] = load_val[4*i +: 4];
         end
      end else if (en) begin
         carry_d = tc;
         if (!(SAT && tc))
            count_d = count_step;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
         carry_q <= 1'b0;
      end else begin
         count_q <= count_d;
         carry_q <= carry_d;
      end
   end

   assign count     = count_q;
   assign carry_out = carry_q;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Self-checking bench for bcd_cascade_counter (2 digits, mod 10 + mod 6).
// Reference model treats the chain as one integer in 0..59.
module tb_bcd_cascade_counter;

   localparam int TOTAL = 60;

   logic       clk = 1'b0;
   logic       reset, en, up, load;
   logic [7:0] load_val;
   logic [7:0] count;
   logic       tc, carry_out;

   int n_checks = 0;
   int n_fail   = 0;

   int  m_n   = 0;
   bit  m_c   = 1'b0;

`ifdef BCD_CASCADE_SATURATE_EN
   localparam bit M_SAT = 1'b1;
`else
   localparam bit M_SAT = 1'b0;
`endif

   bcd_cascade_counter #(.DIGITS(2), .MOD_VEC({4'd6, 4'd10})) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .up        (up),
      .load      (load),
      .load_val  (load_val),
      .count     (count),
      .tc        (tc),
      .carry_out (carry_out)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] enc(int n);
      logic [7:0] r;
      r[3:0] = 4'(n % 10);
      r[7:4] = 4'(n / 10);
      return r;
   endfunction

   function automatic int clamp_val(logic [7:0] v);
      int lo, hi;
      lo = int'(v[3:0]);
      hi = int'(v[7:4]);
      if (lo > 9) lo = 9;
      if (hi > 5) hi = 5;
      return hi * 10 + lo;
   endfunction

   function automatic bit m_tc();
      return up ? (m_n == TOTAL - 1) : (m_n == 0);
   endfunction

   task automatic chk(string tag);
      logic [7:0] e_cnt;
      bit         e_tc;
      e_cnt = enc(m_n);
      e_tc  = m_tc();
      n_checks++;
      assert (count === e_cnt) else begin
         n_fail++;
         $error("FAIL %s count observed %h expected %h", tag, count, e_cnt);
      end
      n_checks++;
      assert (carry_out === m_c) else begin
         n_fail++;
         $error("FAIL %s carry_out observed %b expected %b", tag, carry_out, m_c);
      end
      n_checks++;
      assert (tc === e_tc) else begin
         n_fail++;
         $error("FAIL %s tc observed %b expected %b", tag, tc, e_tc);
      end
   endtask

   // One clock edge: advance the model from the inputs, then check 1 time unit later.
   task automatic step(string tag);
      bit t;
      @(posedge clk);
      t = m_tc();
      if (!reset) begin
         m_n = 0;
         m_c = 1'b0;
      end else if (load) begin
         m_n = clamp_val(load_val);
         m_c = 1'b0;
      end else if (en) begin
         m_c = t;
         if (!(M_SAT && t))
            m_n = up ? (m_n + 1) % TOTAL : (m_n + TOTAL - 1) % TOTAL;
      end else begin
         m_c = 1'b0;
      end
      #1;
      chk(tag);
   endtask

   task automatic do_load(logic [7:0] v, string tag);
      load     = 1'b1;
      load_val = v;
      step(tag);
      load = 1'b0;
   endtask

   initial begin
      reset = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 8'h00;
      #1;
      step("reset1");
      step("reset2");
      reset = 1'b1;

      for (int i = 0; i < 60; i++) step("count_up");

      en = 1'b0;
      step("hold");

      en = 1'b1;
      do_load(8'h7C, "load_clamp");
      en = 1'b0;
      step("load_tc");

      up = 1'b0;
      en = 1'b1;
      do_load(8'h10, "load10");
      step("borrow");
      do_load(8'h00, "load00");
      step("down_wrap");
      step("down_after_wrap");

      // tc follows direction combinationally
      en = 1'b0;
      do_load(8'h00, "load00b");
      up = 1'b1;
      #1; chk("tc_dir_up");
      up = 1'b0;
      #1; chk("tc_dir_down");

      up = 1'b1;
      en = 1'b1;
      do_load(8'h37, "load37");
      reset = 1'b0;
      step("mid_reset");
      reset = 1'b1;
      step("resume");

      do_load(8'h59, "load59");
      for (int i = 0; i < 3; i++) step("at_max_step");
      en = 1'b0;
      step("at_max_hold");

      for (int i = 0; i < 400; i++) begin
         reset    = ($urandom_range(0, 49) != 0);
         load     = ($urandom_range(0, 9) == 0);
         en       = ($urandom_range(0, 3) != 0);
         up       = ($urandom_range(0, 5) != 0) ? up : ~up;
         load_val = 8'($urandom);
         step("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
